// File: rtl/sdio_pkg.sv
// Shared definitions for the SD data-line packer: FSM states, CRC16 polynomial, error bit map.
package sdio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_DATA       = 3'd2,
    ST_CRC        = 3'd3,
    ST_END_BIT    = 3'd4,
    ST_DONE       = 3'd5
  } sdio_state_t;

  // CRC16-CCITT, x^16 + x^12 + x^5 + 1 (x^16 term implicit)
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  // blk_err = {timeout, overrun, crc}
  localparam int unsigned ERR_CRC = 0;
  localparam int unsigned ERR_OVR = 1;
  localparam int unsigned ERR_TMO = 2;

endpackage

// File: rtl/sdio_crc16.sv
// Bit-serial CRC16 for one SD DAT line; MSB-first, initial value 0.
module sdio_crc16
  import sdio_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic w_fb;
  assign w_fb = i_bit ^ o_crc[15];

  // Shift one data bit into the remainder per enabled cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_crc <= 16'h0000;
    end else if (i_clr) begin
      o_crc <= 16'h0000;
    end else if (i_en) begin
      o_crc <= {o_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sdio_data_packer.sv
// SD 4-bit data block receiver: nibbles -> little-endian 32-bit words with a one-deep output slot.
// Optional per-line CRC16 checking is built when SDIO_CRC_CHECK_EN is defined; otherwise
// the CRC nibbles are skipped and only the end bit is checked.
module sdio_data_packer
  import sdio_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES   = 512,
  parameter int unsigned START_TIMEOUT = 65535
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        sd_strobe,
  input  logic [3:0]  sd_dat,
  input  logic        blk_arm,
  output logic        busy,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        blk_done,
  output logic [2:0]  blk_err
);

  localparam int unsigned NIB_W = $clog2(2 * BLOCK_BYTES);
  localparam int unsigned TMO_W = $clog2(START_TIMEOUT + 1);

  sdio_state_t      r_state;
  logic [NIB_W-1:0] r_nib_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [3:0]       r_crc_cnt;
  logic [31:0]      r_word;
  logic [31:0]      w_word;
  logic             w_crc_bad;

  // The eighth nibble of a word is the low nibble of byte 3
  assign w_word = {r_word[31:28], sd_dat, r_word[23:0]};

`ifdef SDIO_CRC_CHECK_EN
  logic [3:0][15:0] w_crc;
  logic [3:0][15:0] r_rx_crc;
  logic             w_crc_clr;
  logic             w_crc_en;

  assign w_crc_clr = (r_state == ST_IDLE) && blk_arm;
  assign w_crc_en  = (r_state == ST_DATA) && sd_strobe;

  for (genvar g = 0; g < 4; g++) begin : g_crc
    sdio_crc16 u_crc16 (
      .i_clk (ACLK),
      .i_rst (ARESET),
      .i_clr (w_crc_clr),
      .i_en  (w_crc_en),
      .i_bit (sd_dat[g]),
      .o_crc (w_crc[g])
    );
  end

  // Collect the received CRC bits, MSB first, per line
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rx_crc <= '0;
    end else if ((r_state == ST_CRC) && sd_strobe) begin
      for (int i = 0; i < 4; i++) begin
        r_rx_crc[i] <= {r_rx_crc[i][14:0], sd_dat[i]};
      end
    end
  end

  assign w_crc_bad = (w_crc != r_rx_crc);
`else
  assign w_crc_bad = 1'b0;
`endif

  // Block FSM, nibble packing, output slot and error accumulation
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= ST_IDLE;
      r_nib_cnt <= '0;
      r_tmo_cnt <= '0;
      r_crc_cnt <= '0;
      r_word    <= '0;
      busy      <= 1'b0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      blk_done  <= 1'b0;
      blk_err   <= '0;
    end else begin
      blk_done <= 1'b0;
      if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (blk_arm) begin
            r_state   <= ST_WAIT_START;
            r_tmo_cnt <= '0;
            blk_err   <= '0;
            busy      <= 1'b1;
          end
        end
        ST_WAIT_START: begin
          if (sd_strobe) begin
            if (sd_dat == 4'h0) begin
              r_state   <= ST_DATA;
              r_nib_cnt <= '0;
            end else if (r_tmo_cnt == TMO_W'(START_TIMEOUT - 1)) begin
              r_state          <= ST_DONE;
              blk_done         <= 1'b1;
              blk_err[ERR_TMO] <= 1'b1;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (sd_strobe) begin
            r_word[{r_nib_cnt[2:1], ~r_nib_cnt[0], 2'b00} +: 4] <= sd_dat;
            r_nib_cnt <= r_nib_cnt + NIB_W'(1);
            if (r_nib_cnt[2:0] == 3'd7) begin
              // A slot being accepted this cycle is free for the new word
              if (m_tvalid && !m_tready) begin
                blk_err[ERR_OVR] <= 1'b1;
              end else begin
                m_tvalid <= 1'b1;
                m_tdata  <= w_word;
              end
            end
            if (r_nib_cnt == NIB_W'(2 * BLOCK_BYTES - 1)) begin
              r_state   <= ST_CRC;
              r_crc_cnt <= '0;
            end
          end
        end
        ST_CRC: begin
          if (sd_strobe) begin
            r_crc_cnt <= r_crc_cnt + 4'd1;
            if (r_crc_cnt == 4'd15) begin
              r_state <= ST_END_BIT;
            end
          end
        end
        ST_END_BIT: begin
          if (sd_strobe) begin
            if ((sd_dat != 4'hF) || w_crc_bad) begin
              blk_err[ERR_CRC] <= 1'b1;
            end
            r_state  <= ST_DONE;
            blk_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdio_data_packer.sv
// Directed + randomized bench for sdio_data_packer with a word-level reference model.
module tb_sdio_data_packer;

  localparam int unsigned NIBS = 1024;
`ifdef SDIO_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        sd_strobe;
  logic [3:0]  sd_dat;
  logic        blk_arm;
  logic        busy;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        blk_done;
  logic [2:0]  blk_err;

  sdio_data_packer #(.BLOCK_BYTES(512), .START_TIMEOUT(16)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .sd_strobe (sd_strobe),
    .sd_dat    (sd_dat),
    .blk_arm   (blk_arm),
    .busy      (busy),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .blk_done  (blk_done),
    .blk_err   (blk_err)
  );

  always #5 ACLK = ~ACLK;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  blk_nib [NIBS];
  logic [31:0] exp_q [$];
  bit          mdl_ovr;
  int          hs_cnt;
  logic [31:0] first_hs;
  int          done_cnt;
  logic [2:0]  done_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic pick_rdy(input int rmode);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return 1'b0;
    return ($urandom_range(0, 3) != 0);
  endfunction

  // Word n/8 of the block: byte j = {nibble 2j, nibble 2j+1}, byte 0 in the low bits
  function automatic logic [31:0] word_at(input int base);
    logic [31:0] w = 32'h0;
    for (int j = 0; j < 4; j++) begin
      w = w | (32'({blk_nib[base + 2*j], blk_nib[base + 2*j + 1]}) << (8 * j));
    end
    return w;
  endfunction

  // CRC16 of one line as the remainder of M(x)*x^16 divided by G(x), by long division
  function automatic logic [15:0] crc_line(input int ln);
    logic        r [NIBS + 16];
    logic [16:0] gp = 17'h11021;
    logic [15:0] c;
    for (int i = 0; i < NIBS; i++) r[i] = blk_nib[i][ln];
    for (int i = NIBS; i < NIBS + 16; i++) r[i] = 1'b0;
    for (int i = 0; i < NIBS; i++) begin
      if (r[i]) begin
        for (int j = 0; j <= 16; j++) r[i + j] = r[i + j] ^ gp[16 - j];
      end
    end
    for (int k = 0; k < 16; k++) c[15 - k] = r[NIBS + k];
    return c;
  endfunction

  // One clock: drive inputs, check the output slot against the model, advance
  task automatic cyc(input logic stb, input logic [3:0] dat, input logic arm,
                     input logic rdy, input logic word_end, input logic [31:0] word);
    sd_strobe = stb;
    sd_dat    = dat;
    blk_arm   = arm;
    m_tready  = rdy;
    #1;
    chk("tvalid", 32'(m_tvalid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("tdata", m_tdata, exp_q[0]);
    if (exp_q.size() != 0 && rdy) begin
      if (hs_cnt == 0) first_hs = m_tdata;
      hs_cnt++;
      void'(exp_q.pop_front());
    end
    if (word_end) begin
      if (exp_q.size() != 0) mdl_ovr = 1'b1;
      else exp_q.push_back(word);
    end
    @(posedge ACLK);
    @(negedge ACLK);
    if (blk_done === 1'b1) begin
      done_cnt++;
      done_err = blk_err;
    end
  endtask

  task automatic gaps(input int rmode);
    repeat ($urandom_range(0, 2))
      cyc(1'b0, 4'($urandom), (rmode == 2) && ($urandom_range(0, 15) == 0),
          pick_rdy(rmode), 1'b0, 32'h0);
  endtask

  // Full block transfer; stop_at > 0 abandons the block after that many data nibbles
  task automatic send_block(input int rmode, input bit flip, input logic [3:0] end_nib,
                            input int stop_at);
    logic [15:0] crc [4];
    logic [3:0]  nib;
    logic [2:0]  exp_err;
    done_cnt = 0;
    hs_cnt   = 0;
    mdl_ovr  = 1'b0;
    cyc(1'b0, 4'($urandom), 1'b1, pick_rdy(rmode), 1'b0, 32'h0);
    chk("busy_armed", 32'(busy), 32'd1);
    repeat ($urandom_range(0, 3)) begin
      gaps(rmode);
      cyc(1'b1, 4'hF, 1'b0, pick_rdy(rmode), 1'b0, 32'h0);
    end
    gaps(rmode);
    cyc(1'b1, 4'h0, 1'b0, pick_rdy(rmode), 1'b0, 32'h0);
    for (int n = 0; n < NIBS; n++) begin
      gaps(rmode);
      cyc(1'b1, blk_nib[n], 1'b0, pick_rdy(rmode), (n % 8) == 7,
          ((n % 8) == 7) ? word_at(n - 7) : 32'h0);
      if (stop_at == n + 1) return;
    end
    for (int ln = 0; ln < 4; ln++) crc[ln] = crc_line(ln);
    for (int k = 0; k < 16; k++) begin
      for (int ln = 0; ln < 4; ln++) nib[ln] = crc[ln][15 - k];
      if (flip && k == 15) nib[2] = ~nib[2];
      gaps(rmode);
      cyc(1'b1, nib, 1'b0, pick_rdy(rmode), 1'b0, 32'h0);
    end
    gaps(rmode);
    cyc(1'b1, end_nib, 1'b0, pick_rdy(rmode), 1'b0, 32'h0);
    exp_err = {1'b0, mdl_ovr, (end_nib != 4'hF) || (flip && CRC_EN)};
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("blk_err", 32'(done_err), 32'(exp_err));
    cyc(1'b0, 4'($urandom), 1'b0, pick_rdy(rmode), 1'b0, 32'h0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic drain;
    repeat (3) cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    ARESET    = 1'b1;
    sd_strobe = 1'b0;
    sd_dat    = 4'h0;
    blk_arm   = 1'b0;
    m_tready  = 1'b1;
    hs_cnt    = 0;
    done_cnt  = 0;
    repeat (2) @(negedge ACLK);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", m_tdata, 32'h0);
    chk("rst_done", 32'(blk_done), 32'd0);
    chk("rst_err", 32'(blk_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    ARESET = 1'b0;

    // Counting pattern, clean block
    for (int i = 0; i < NIBS; i++) blk_nib[i] = 4'(i % 16);
    send_block(0, 1'b0, 4'hF, -1);
    chk("clean_words", 32'(hs_cnt), 32'd128);
    chk("clean_first", first_hs, 32'h67452301);
    chk("clean_err", 32'(done_err), 32'h0);

    // Line-2 CRC bit 0 corrupted
    send_block(0, 1'b1, 4'hF, -1);
    chk("crcflip_err", 32'(done_err), CRC_EN ? 32'h1 : 32'h0);

    // Downstream stalled for the whole block
    send_block(1, 1'b0, 4'hF, -1);
    chk("stall_err", 32'(done_err), 32'h2);
    drain();
    chk("stall_words", 32'(hs_cnt), 32'd1);
    chk("stall_first", first_hs, 32'h67452301);

    // Start-bit timeout
    done_cnt = 0;
    hs_cnt   = 0;
    cyc(1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0);
      cyc(1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("tmo_done", 32'(blk_done), 32'(k == 16));
    end
    chk("tmo_err", 32'(done_err), 32'h4);
    cyc(1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_words", 32'(hs_cnt), 32'd0);

    // Reset mid-block, then a clean random block
    for (int i = 0; i < NIBS; i++) blk_nib[i] = 4'($urandom);
    send_block(0, 1'b0, 4'hF, 300);
    #2 ARESET = 1'b1;
    sd_strobe = 1'b0;
    #1;
    chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(blk_done), 32'd0);
    exp_q.delete();
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    chk("midrst_nodone", 32'(done_cnt), 32'd0);
    for (int i = 0; i < NIBS; i++) blk_nib[i] = 4'($urandom);
    send_block(0, 1'b0, 4'hF, -1);
    chk("postrst_words", 32'(hs_cnt), 32'd128);
    chk("postrst_err", 32'(done_err), 32'h0);

    // Bad end bit
    send_block(0, 1'b0, 4'h7, -1);
    chk("endbit_err", 32'(done_err), 32'h1);

    // Random data with random backpressure and stray arm pulses
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < NIBS; i++) blk_nib[i] = 4'($urandom);
      send_block(2, 1'b0, 4'hF, -1);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
